// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped, one-word-per-line instruction cache sitting
// between the IF stage and the byte-serial memory controller. Hits are served
// from local storage one cycle after the lookup; misses issue one controller
// read, fill the line and forward the word. A flush invalidates every line in
// one cycle and abandons any response still in flight.
module icache_fetch #(
   parameter int ADDR_W     = 32,
   parameter int INDEX_BITS = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy_in,
   input  logic              flush_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ready_o,
   output logic              inst_valid_o,
   output logic [31:0]       inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_done_i,
   input  logic [31:0]       mem_inst_i
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOOKUP  = 2'd1;
   localparam logic [1:0] S_MISS    = 2'd2;
   localparam logic [1:0] S_DISCARD = 2'd3;

   logic [1:0]            state;
   logic [ADDR_W-1:0]     req_addr;     // word-aligned address of the request being served
   logic [LINES-1:0]      valid;
   logic [TAG_W-1:0]      tag_mem  [LINES];
   logic [31:0]           data_mem [LINES];

   logic [INDEX_BITS-1:0] req_index;
   logic [TAG_W-1:0]      req_tag;
   logic                  hit;
   logic                  fill;
   logic                  unused_byte_bits;

   // Byte offset of the fetch PC carries no information for a word cache.
   assign unused_byte_bits = ^if_addr_i[1:0];

   assign req_index = req_addr[INDEX_BITS+1:2];
   assign req_tag   = req_addr[ADDR_W-1:INDEX_BITS+2];
   assign hit       = valid[req_index] && (tag_mem[req_index] == req_tag);

   // A line is written only by a controller response that is still wanted.
   assign fill = rdy_in && (state == S_MISS) && mem_done_i && !flush_i;

   // The global stall gates acceptance as well as every state change.
   assign if_ready_o = rdy_in && (state == S_IDLE);

   // Tag and data arrays: written on fill, read during LOOKUP.
   // NOTE: the arrays have no reset; the valid bits alone decide whether a
   // line's contents mean anything, so clearing them keeps the arrays RAM-able.
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_mem[req_index]  <= req_tag;
         data_mem[req_index] <= mem_inst_i;
      end
   end

   // Control FSM, valid bits and registered outputs.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // branch below sees the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         req_addr     <= '0;
         valid        <= '0;
         inst_valid_o <= 1'b0;
         inst_o       <= '0;
         inst_addr_o  <= '0;
         mem_req_o    <= 1'b0;
         mem_addr_o   <= '0;
      end else if (rdy_in) begin
         inst_valid_o <= 1'b0;
         if (flush_i) begin
            valid <= '0;
         end
         case (state)
            S_IDLE: begin
               if (if_req_i && !flush_i) begin
                  req_addr <= {if_addr_i[ADDR_W-1:2], 2'b00};
                  state    <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (flush_i) begin
                  state <= S_IDLE;
               end else if (hit) begin
                  inst_valid_o <= 1'b1;
                  inst_o       <= data_mem[req_index];
                  inst_addr_o  <= req_addr;
                  state        <= S_IDLE;
               end else begin
                  mem_req_o  <= 1'b1;
                  mem_addr_o <= req_addr;
                  state      <= S_MISS;
               end
            end
            S_MISS: begin
               if (mem_done_i) begin
                  mem_req_o <= 1'b0;
                  state     <= S_IDLE;
                  if (!flush_i) begin
                     valid[req_index] <= 1'b1;
                     inst_valid_o     <= 1'b1;
                     inst_o           <= mem_inst_i;
                     inst_addr_o      <= req_addr;
                  end
               end else if (flush_i) begin
                  // The controller read cannot be cancelled; wait it out.
                  state <= S_DISCARD;
               end
            end
            S_DISCARD: begin
               if (mem_done_i) begin
                  mem_req_o <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_fetch.sv
// tb_icache_fetch: scoreboard bench for icache_fetch. The driver predicts each
// response from a line-level cache model plus a memory model and queues it;
// a negedge monitor pops and compares every inst_valid_o pulse.
module tb_icache_fetch;

   localparam int ADDR_W = 32;
   localparam int IB     = 6;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              rdy_in = 1'b1;
   logic              flush_i = 1'b0;
   logic              if_req_i = 1'b0;
   logic [ADDR_W-1:0] if_addr_i = '0;
   logic              if_ready_o;
   logic              inst_valid_o;
   logic [31:0]       inst_o;
   logic [ADDR_W-1:0] inst_addr_o;
   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_done_i = 1'b0;
   logic [31:0]       mem_inst_i = '0;

   icache_fetch #(.ADDR_W(ADDR_W), .INDEX_BITS(IB)) dut (
      .clk          (clk),
      .rst          (rst),
      .rdy_in       (rdy_in),
      .flush_i      (flush_i),
      .if_req_i     (if_req_i),
      .if_addr_i    (if_addr_i),
      .if_ready_o   (if_ready_o),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .inst_addr_o  (inst_addr_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_done_i   (mem_done_i),
      .mem_inst_i   (mem_inst_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   logic edge_rdy = 1'b0;

   // Reference model: one entry per line, plus a memory image.
   bit          m_valid [1 << IB];
   logic [31:0] m_addr  [1 << IB];
   logic [31:0] m_data  [1 << IB];
   logic [31:0] mem_ovr [logic [31:0]];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] wa);
      if (mem_ovr.exists(wa)) return mem_ovr[wa];
      return (wa * 32'h9E37_79B1) ^ 32'h0123_4567;
   endfunction

   function automatic void model_flush();
      for (int i = 0; i < (1 << IB); i++) m_valid[i] = 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // A pulse is new only if the edge that produced it was not stalled.
   always @(posedge clk) edge_rdy = rdy_in;

   // Monitor: every fresh inst_valid_o pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst && edge_rdy && inst_valid_o) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got inst 0x%08h addr 0x%08h, expected no pulse at %0t",
                     inst_o, inst_addr_o, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("inst_addr", inst_addr_o, mon_e.addr);
            check("inst_data", inst_o, mon_e.data);
         end
      end
   end

   task automatic do_flush();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      model_flush();
   endtask

   // Full fetch transaction with model-based hit/miss prediction.
   task automatic fetch(input logic [31:0] addr, input int delay, input bit stall);
      logic [31:0] wa;
      int          idx;
      bit          hit;
      bit          held;
      logic [31:0] d;
      int          n;
      wa  = {addr[31:2], 2'b00};
      idx = int'(wa[IB+1:2]);
      hit = m_valid[idx] && (m_addr[idx] == wa);
      d   = hit ? m_data[idx] : mem_word(wa);
      n   = 0;
      while (!if_ready_o && n < 20) begin
         tick();
         n++;
      end
      check("if_ready_idle", 32'(if_ready_o), 32'd1);
      if_req_i  = 1'b1;
      if_addr_i = addr;
      exp_q.push_back('{wa, d});
      tick();
      if_req_i  = 1'b0;
      if_addr_i = $urandom;
      check("busy_after_accept", 32'(if_ready_o), 32'd0);
      tick();
      if (hit) begin
         check("hit_valid", 32'(inst_valid_o), 32'd1);
         check("hit_no_mem", 32'(mem_req_o), 32'd0);
      end else begin
         check("miss_req", 32'(mem_req_o), 32'd1);
         check("miss_addr", mem_addr_o, wa);
         check("miss_quiet", 32'(inst_valid_o), 32'd0);
         held = 1'b1;
         for (int i = 0; i < delay; i++) begin
            tick();
            if (!mem_req_o || mem_addr_o != wa) held = 1'b0;
         end
         if (stall) begin
            rdy_in = 1'b0;
            for (int i = 0; i < 4; i++) begin
               if (i == 1) begin
                  mem_done_i = 1'b1;
                  mem_inst_i = 32'hBADC_0DE5;
               end
               tick();
               mem_done_i = 1'b0;
               if (!mem_req_o || mem_addr_o != wa || if_ready_o) held = 1'b0;
            end
            rdy_in = 1'b1;
            tick();
            if (!mem_req_o || mem_addr_o != wa) held = 1'b0;
         end
         check("miss_held", 32'(held), 32'd1);
         mem_done_i = 1'b1;
         mem_inst_i = d;
         tick();
         mem_done_i = 1'b0;
         check("fill_drop_req", 32'(mem_req_o), 32'd0);
         m_valid[idx] = 1'b1;
         m_addr[idx]  = wa;
         m_data[idx]  = d;
      end
      tick();
      check("drained", 32'(exp_q.size()), 32'd0);
   endtask

   // Drive a request known to miss and stop once the controller read is up.
   task automatic start_miss(input logic [31:0] addr);
      if_req_i  = 1'b1;
      if_addr_i = addr;
      tick();
      if_req_i  = 1'b0;
      tick();
      check("start_miss_req", 32'(mem_req_o), 32'd1);
   endtask

   initial begin
      model_flush();
      mem_ovr[32'h0000_0100] = 32'h0050_0093;
      #12;
      check("rst_if_ready", 32'(if_ready_o), 32'd1);
      check("rst_inst_valid", 32'(inst_valid_o), 32'd0);
      check("rst_mem_req", 32'(mem_req_o), 32'd0);
      check("rst_inst", inst_o, 32'd0);
      check("rst_inst_addr", inst_addr_o, 32'd0);
      check("rst_mem_addr", mem_addr_o, 32'd0);
      tick();
      rst = 1'b1;
      tick();

      // Cold miss then hit.
      fetch(32'h0000_0100, 5, 1'b0);
      fetch(32'h0000_0100, 0, 1'b0);
      // Conflict eviction at index 0.
      fetch(32'h0000_0200, 2, 1'b0);
      fetch(32'h0000_0100, 1, 1'b0);
      // Flush in IDLE.
      do_flush();
      fetch(32'h0000_0100, 1, 1'b0);

      // Flush mid-miss: response must be discarded.
      start_miss(32'h0000_0104);
      tick();
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      model_flush();
      check("discard_req_held", 32'(mem_req_o), 32'd1);
      check("discard_busy", 32'(if_ready_o), 32'd0);
      tick();
      tick();
      mem_done_i = 1'b1;
      mem_inst_i = 32'hDEAD_BEEF;
      tick();
      mem_done_i = 1'b0;
      check("discard_drop_req", 32'(mem_req_o), 32'd0);
      check("discard_idle", 32'(if_ready_o), 32'd1);
      tick();
      fetch(32'h0000_0104, 1, 1'b0);

      // Flush and mem_done_i together in MISS.
      start_miss(32'h0000_0108);
      tick();
      flush_i    = 1'b1;
      mem_done_i = 1'b1;
      mem_inst_i = 32'h1111_2222;
      tick();
      flush_i    = 1'b0;
      mem_done_i = 1'b0;
      model_flush();
      check("flushdone_req", 32'(mem_req_o), 32'd0);
      check("flushdone_idle", 32'(if_ready_o), 32'd1);
      tick();
      fetch(32'h0000_0108, 0, 1'b0);

      // rdy_in stall with an ignored mem_done_i pulse.
      fetch(32'h0000_010C, 1, 1'b1);

      // Asynchronous reset during MISS, then a late response.
      start_miss(32'h0000_0110);
      tick();
      #2;
      rst = 1'b0;
      #1;
      check("amid_rst_mem_req", 32'(mem_req_o), 32'd0);
      check("amid_rst_if_ready", 32'(if_ready_o), 32'd1);
      tick();
      rst = 1'b1;
      model_flush();
      tick();
      mem_done_i = 1'b1;
      mem_inst_i = 32'hCAFE_F00D;
      tick();
      mem_done_i = 1'b0;
      check("late_done_req", 32'(mem_req_o), 32'd0);
      tick();
      fetch(32'h0000_0100, 2, 1'b0);

      // Randomized traffic over a small address pool to mix hits and conflicts.
      for (int k = 0; k < 150; k++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 3) << (IB + 2)) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 9) == 0) do_flush();
         if ($urandom_range(0, 7) == 0) begin
            mem_done_i = 1'b1;
            mem_inst_i = $urandom;
            tick();
            mem_done_i = 1'b0;
         end
         fetch(a, $urandom_range(0, 4), $urandom_range(0, 5) == 0);
      end

      tick();
      tick();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
